mux_select_bank: RTL and testbench
==================================

Name: mux_select_bank

Overview:
N-bit multiplexer bank with three independent selectors over a shared set of eight data inputs: 2:1, 4:1 and 8:1.
- Each selector drives a combinational output for same-cycle datapath use.
- Each selector also drives a registered copy for timing-isolated consumers.
- Used as a generic operand/result selection stage in the datapath.

Parameters:
- N, 32, data width of every input and output word.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  asynchronous, active-high reset; clears all registered outputs.
- input_1..input_8  input  N each  data words; input_k is selected by select value k-1.
- select_2  input  1  selector for the 2:1 path (chooses input_1/input_2).
- select_4  input  2  selector for the 4:1 path (input_1..input_4).
- select_8  input  3  selector for the 8:1 path (input_1..input_8).
- mux_output_2  output  N  combinational 2:1 result.
- mux_output_4  output  N  combinational 4:1 result.
- mux_output_8  output  N  combinational 8:1 result.
- mux_output_2_q  output  N  registered 2:1 result.
- mux_output_4_q  output  N  registered 4:1 result.
- mux_output_8_q  output  N  registered 8:1 result.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Combinational paths (zero latency, independent of clk/rst):
  - mux_output_2 = select_2 ? input_2 : input_1.
  - mux_output_4 = input_(select_4+1).
  - mux_output_8 = input_(select_8+1).
  - Every select encoding is valid, so there is no default/illegal case.
  - Outputs follow any input or select change within the same delta cycle; no latches.
- Registered paths:
  - On each rising clk edge with rst low, each *_q output captures its combinational counterpart. Latency is exactly 1 cycle.
  - rst high: all *_q outputs go to 0 immediately (asynchronous), regardless of clk, and are held at 0 while rst is asserted.
  - Release of rst: the first capture occurs at the first rising edge after deassertion.
  - Reset asserted mid-operation discards in-flight values. Combinational outputs are unaffected by rst.
- The three selectors are fully independent. They may select the same input simultaneously with no interaction.
- Width rule: outputs are exactly N bits, with no extension or truncation.
- Implementation: each wider mux is built hierarchically from 2:1 stages.
  - 4:1 = two 2:1 on select[0], then a 2:1 on select[1].
  - 8:1 = two 4:1 on select[1:0], then a 2:1 on select[2].

Optional Feature:
- Macro: MUX_PARITY_EN.
- When defined:
  - Adds output mux_parity_q, 3 bits, registered together with the *_q outputs.
  - Bit 0 is the XOR-reduction of mux_output_2, bit 1 of mux_output_4, bit 2 of mux_output_8, each captured on the same edge.
  - mux_parity_q resets to 0 asynchronously with rst.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Select sweep, combinational: input_k = 32'h1111_1111*k.
  - select_2 = 0 then 1 -> mux_output_2 = 32'h1111_1111 then 32'h2222_2222.
  - select_4 = 0..3 -> 32'h1111_1111..32'h4444_4444.
  - select_8 = 7 -> 32'h8888_8888.
- Random regression: 1000 iterations of random inputs with every select value -> each combinational output equals the selected input after settling.
- Register latency: select_8 = 3, input_4 = 32'hDEAD_BEEF.
  - mux_output_8_q = 32'hDEAD_BEEF after 1 rising edge, not before.
  - Changing select_8 to 5 mid-cycle leaves *_q unchanged until the next edge.
- Async reset: with *_q nonzero, assert rst between clock edges -> all *_q = 0 immediately while combinational outputs still track inputs. Deassert rst -> *_q reloads on the next edge.
- Shared selection: select_2 = 1, select_4 = 1, select_8 = 1 -> all three outputs equal input_2.
- With MUX_PARITY_EN: input_1 = 32'h0000_0001, all selects 0 -> mux_parity_q = 3'b111 one cycle later. With input_1 = 32'h0000_0003 -> 3'b000.

Source files
------------

// File: rtl/mux_select_bank.sv
// ============================================================================
// Module      : mux_select_bank
// Description : 2:1, 4:1 and 8:1 selectors sharing eight N-bit data words.
//               Each selector has a combinational output and a registered copy.
//               Optional macro MUX_PARITY_EN adds registered per-path parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_select_bank #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] input_1,
  input  logic [N-1:0] input_2,
  input  logic [N-1:0] input_3,
  input  logic [N-1:0] input_4,
  input  logic [N-1:0] input_5,
  input  logic [N-1:0] input_6,
  input  logic [N-1:0] input_7,
  input  logic [N-1:0] input_8,
  input  logic         select_2,
  input  logic [1:0]   select_4,
  input  logic [2:0]   select_8,
  output logic [N-1:0] mux_output_2,
  output logic [N-1:0] mux_output_4,
  output logic [N-1:0] mux_output_8,
  output logic [N-1:0] mux_output_2_q,
  output logic [N-1:0] mux_output_4_q,
  output logic [N-1:0] mux_output_8_q
`ifdef MUX_PARITY_EN
  ,
  output logic [2:0]   mux_parity_q
`endif
);

  function automatic logic [N-1:0] mux2(input logic s, input logic [N-1:0] a,
                                        input logic [N-1:0] b);
    return s ? b : a;
  endfunction

  // Wider selectors are trees of 2:1 stages, low select bits first.
  logic [N-1:0] w_m4_lo;
  logic [N-1:0] w_m4_hi;
  logic [N-1:0] w_m8_lo_a;
  logic [N-1:0] w_m8_lo_b;
  logic [N-1:0] w_m8_hi_a;
  logic [N-1:0] w_m8_hi_b;
  logic [N-1:0] w_m8_lo;
  logic [N-1:0] w_m8_hi;

  logic [N-1:0] mux_output_2_d;
  logic [N-1:0] mux_output_4_d;
  logic [N-1:0] mux_output_8_d;

  always_comb begin
    mux_output_2_d = mux2(select_2, input_1, input_2);

    w_m4_lo        = mux2(select_4[0], input_1, input_2);
    w_m4_hi        = mux2(select_4[0], input_3, input_4);
    mux_output_4_d = mux2(select_4[1], w_m4_lo, w_m4_hi);

    w_m8_lo_a      = mux2(select_8[0], input_1, input_2);
    w_m8_lo_b      = mux2(select_8[0], input_3, input_4);
    w_m8_lo        = mux2(select_8[1], w_m8_lo_a, w_m8_lo_b);
    w_m8_hi_a      = mux2(select_8[0], input_5, input_6);
    w_m8_hi_b      = mux2(select_8[0], input_7, input_8);
    w_m8_hi        = mux2(select_8[1], w_m8_hi_a, w_m8_hi_b);
    mux_output_8_d = mux2(select_8[2], w_m8_lo, w_m8_hi);
  end

  assign mux_output_2 = mux_output_2_d;
  assign mux_output_4 = mux_output_4_d;
  assign mux_output_8 = mux_output_8_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_output_2_q <= '0;
      mux_output_4_q <= '0;
      mux_output_8_q <= '0;
    end else begin
      mux_output_2_q <= mux_output_2_d;
      mux_output_4_q <= mux_output_4_d;
      mux_output_8_q <= mux_output_8_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic [2:0] mux_parity_d;

  assign mux_parity_d = {^mux_output_8_d, ^mux_output_4_d, ^mux_output_2_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mux_parity_q <= 3'b000;
    end else begin
      mux_parity_q <= mux_parity_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_select_bank.sv
// ============================================================================
// Module      : tb_mux_select_bank
// Description : Self-checking bench for mux_select_bank against an array-indexed
//               reference model; parity checks compiled in with MUX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_select_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din [1:8];
  logic        select_2 = 1'b0;
  logic [1:0]  select_4 = 2'd0;
  logic [2:0]  select_8 = 3'd0;
  logic [31:0] o2, o4, o8, q2, q4, q8;
`ifdef MUX_PARITY_EN
  logic [2:0]  par_q;
`endif

  int checks = 0;
  int passes = 0;

  logic [31:0] exp2q, exp4q, exp8q;

  always #5 clk = ~clk;

  mux_select_bank #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .input_1(din[1]), .input_2(din[2]), .input_3(din[3]), .input_4(din[4]),
    .input_5(din[5]), .input_6(din[6]), .input_7(din[7]), .input_8(din[8]),
    .select_2(select_2), .select_4(select_4), .select_8(select_8),
    .mux_output_2(o2), .mux_output_4(o4), .mux_output_8(o8),
    .mux_output_2_q(q2), .mux_output_4_q(q4), .mux_output_8_q(q8)
`ifdef MUX_PARITY_EN
    , .mux_parity_q(par_q)
`endif
  );

  // Reference: a selector value s picks word s+1 from the input array.
  function automatic logic [31:0] pick(input int s);
    return din[s + 1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp2q <= '0;
      exp4q <= '0;
      exp8q <= '0;
    end else begin
      exp2q <= pick(int'(select_2));
      exp4q <= pick(int'(select_4));
      exp8q <= pick(int'(select_8));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
    else passes++;
  endtask

  task automatic test_reset();
    for (int k = 1; k <= 8; k++) din[k] = 32'h1111_1111 * k;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_q2", q2, 32'h0);
    chk("reset_q4", q4, 32'h0);
    chk("reset_q8", q8, 32'h0);
    chk("reset_comb2", o2, 32'h1111_1111);
    rst = 1'b0;
  endtask

  task automatic test_select_sweep();
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      select_2 = 1'(s);
      #1 chk($sformatf("sweep2_s%0d", s), o2, 32'h1111_1111 * (s + 1));
    end
    for (int s = 0; s < 4; s++) begin
      select_4 = 2'(s);
      #1 chk($sformatf("sweep4_s%0d", s), o4, 32'h1111_1111 * (s + 1));
    end
    for (int s = 0; s < 8; s++) begin
      select_8 = 3'(s);
      #1 chk($sformatf("sweep8_s%0d", s), o8, 32'h1111_1111 * (s + 1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      for (int k = 1; k <= 8; k++) din[k] = $urandom;
      select_2 = 1'(i % 2);
      select_4 = 2'($urandom_range(0, 3));
      select_8 = 3'(i % 8);
      #1;
      if (o2 !== din[int'(select_2) + 1]) begin
        checks++; $display("FAIL rand_comb2: got %h expected %h", o2, din[int'(select_2) + 1]);
      end else begin checks++; passes++; end
      if (o4 !== din[int'(select_4) + 1]) begin
        checks++; $display("FAIL rand_comb4: got %h expected %h", o4, din[int'(select_4) + 1]);
      end else begin checks++; passes++; end
      if (o8 !== din[int'(select_8) + 1]) begin
        checks++; $display("FAIL rand_comb8: got %h expected %h", o8, din[int'(select_8) + 1]);
      end else begin checks++; passes++; end
      @(posedge clk);
      #1;
      chk("rand_q2", q2, exp2q);
      chk("rand_q4", q4, exp4q);
      chk("rand_q8", q8, exp8q);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    for (int k = 1; k <= 8; k++) din[k] = 32'h0101_0101 * k;
    select_8 = 3'd0;
    @(posedge clk);
    @(negedge clk);
    select_8 = 3'd3;
    din[4] = 32'hDEAD_BEEF;
    #1 chk("lat_before_edge", q8, 32'h0101_0101);
    @(posedge clk);
    #1 chk("lat_after_edge", q8, 32'hDEAD_BEEF);
    #2 select_8 = 3'd5;
    #1 chk("lat_midcycle_hold", q8, 32'hDEAD_BEEF);
    chk("lat_midcycle_comb", o8, 32'h0606_0606);
    @(posedge clk);
    #1 chk("lat_next_edge", q8, 32'h0606_0606);
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_q2", q2, 32'h0);
    chk("arst_q4", q4, 32'h0);
    chk("arst_q8", q8, 32'h0);
    din[6] = 32'hCAFE_F00D;
    #1 chk("arst_comb_tracks", o8, 32'hCAFE_F00D);
    @(posedge clk);
    #1 chk("arst_hold_q8", q8, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_release_q8", q8, 32'h0);
    @(posedge clk);
    #1 chk("arst_reload_q8", q8, 32'hCAFE_F00D);
    chk("arst_reload_q2", q2, exp2q);
    chk("arst_reload_q4", q4, exp4q);
  endtask

  task automatic test_shared();
    @(negedge clk);
    din[2] = 32'h5A5A_A5A5;
    select_2 = 1'b1;
    select_4 = 2'd1;
    select_8 = 3'd1;
    #1;
    chk("shared_comb2", o2, 32'h5A5A_A5A5);
    chk("shared_comb4", o4, 32'h5A5A_A5A5);
    chk("shared_comb8", o8, 32'h5A5A_A5A5);
    @(posedge clk);
    #1;
    chk("shared_q2", q2, 32'h5A5A_A5A5);
    chk("shared_q4", q4, 32'h5A5A_A5A5);
    chk("shared_q8", q8, 32'h5A5A_A5A5);
  endtask

`ifdef MUX_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    din[1] = 32'h0000_0001;
    select_2 = 1'b0;
    select_4 = 2'd0;
    select_8 = 3'd0;
    @(posedge clk);
    #1 chk("parity_ones", {29'd0, par_q}, 32'h7);
    @(negedge clk);
    din[1] = 32'h0000_0003;
    @(posedge clk);
    #1 chk("parity_zeros", {29'd0, par_q}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("parity_reset", {29'd0, par_q}, 32'h0);
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_select_sweep();
    test_random();
    test_latency();
    test_async_reset();
    test_shared();
`ifdef MUX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
